// File: rtl/calculator_seq.sv
// -----------------------------------------------------------------------------
// calculator_seq
//
// Program-then-execute calculator. The host fills a small instruction memory
// through a valid/ready input, then starts a run. The stored program executes
// in order and each instruction produces one result on a valid/ready output.
// A finished program can be rerun as-is, or discarded with clear.
//
// Instruction word (IW = 2*DATA_W+2 bits):
//   [2W+1:2W] op   00 ADD, 01 SUB, 10 MUL, 11 ACC
//   [2W-1:W]  A    unsigned operand
//   [W-1:0]   B    unsigned operand
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   din        in   instruction word
//   din_valid  in   din qualifier
//   din_ready  out  instruction accepted this cycle (LOAD with room)
//   start      in   single-cycle run request
//   clear      in   discard program, return to LOAD
//   res        out  result magnitude, 2*DATA_W bits
//   res_neg    out  result sign (only SUB can set it)
//   res_index  out  program index of the presented result
//   res_valid  out  result qualifier
//   res_ready  in   consumer accepts the result
//   busy       out  program executing
//   done       out  program finished, waiting for rerun or clear
// -----------------------------------------------------------------------------
module calculator_seq #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*DATA_W+1:0] din,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic                start,
    input  logic                clear,
    output logic [2*DATA_W-1:0] res,
    output logic                res_neg,
    output logic [AW-1:0]       res_index,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                done
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int RW = 2 * DATA_W;    // result width
    localparam int IW = RW + 2;        // instruction width

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    // Counters are one bit wider than the index so that "full" (DEPTH) and
    // "all results issued" (idx == count == DEPTH) are representable.
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LAST_C  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] ZERO_C  = '0;
    localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]    state_q,     state_d;
    logic [AW:0]   count_q,     count_d;      // words in the program
    logic [AW:0]   idx_q,       idx_d;        // next instruction to issue
    logic [RW-1:0] acc_q,       acc_d;        // ACC running sum
    logic [RW-1:0] res_q,       res_d;
    logic          res_neg_q,   res_neg_d;
    logic [AW-1:0] res_index_q, res_index_d;
    logic          res_valid_q, res_valid_d;

    logic [IW-1:0] mem [DEPTH];
    logic          mem_we;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    logic load_xfer;     // instruction word accepted at this edge
    logic out_free;      // output register may take a new result
    logic prog_end;      // every instruction has been issued
    logic last_slot;     // this write fills the memory

    assign din_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign load_xfer = din_valid && din_ready;
    assign out_free  = !res_valid_q || res_ready;
    assign prog_end  = (idx_q == count_q);
    assign last_slot = (count_q == LAST_C);

    // -------------------------------------------------------------------------
    // Instruction memory
    // -------------------------------------------------------------------------
    // NOTE: the memory array has no reset; its contents are meaningless until
    // written and a reset port would prevent mapping it onto RAM primitives.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[count_q[AW-1:0]] <= din;
        end
    end

    // -------------------------------------------------------------------------
    // Decode of the instruction at the fetch pointer. When idx_q has run past
    // the program the read wraps harmlessly; its result is never issued.
    // -------------------------------------------------------------------------
    logic [IW-1:0]     instr;
    logic [1:0]        op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [RW-1:0]     a_ext;
    logic [RW-1:0]     b_ext;

    assign instr = mem[idx_q[AW-1:0]];
    assign op    = instr[IW-1:RW];
    assign op_a  = instr[RW-1:DATA_W];
    assign op_b  = instr[DATA_W-1:0];
    assign a_ext = {{DATA_W{1'b0}}, op_a};
    assign b_ext = {{DATA_W{1'b0}}, op_b};

    // -------------------------------------------------------------------------
    // Arithmetic. Operands are zero-extended to RW, so the product of two
    // DATA_W values always fits; only ACC can wrap, modulo 2^RW.
    // -------------------------------------------------------------------------
    logic [RW-1:0] prod;
    logic [RW-1:0] alu_res;
    logic          alu_neg;

    assign prod = a_ext * b_ext;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // so that no path leaves it unassigned and infers a latch.
    always_comb begin
        alu_res = '0;
        alu_neg = 1'b0;
        case (op)
            OP_ADD: alu_res = a_ext + b_ext;
            OP_SUB: begin
                // Magnitude/sign form keeps the result unsigned-width.
                if (op_a >= op_b) begin
                    alu_res = a_ext - b_ext;
                end else begin
                    alu_res = b_ext - a_ext;
                    alu_neg = 1'b1;
                end
            end
            OP_MUL: alu_res = prod;
            OP_ACC: alu_res = acc_q + prod;
            default: alu_res = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_neg_d   = res_neg_q;
        res_index_d = res_index_q;
        res_valid_d = res_valid_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (clear) begin
                    // A word offered alongside clear is discarded with the
                    // rest of the program.
                    count_d = ZERO_C;
                end else begin
                    if (load_xfer) begin
                        mem_we  = 1'b1;
                        count_d = count_q + ONE_C;
                    end
                    // start counts the word written at the same edge, so a
                    // first-word-plus-start still runs. Filling the last slot
                    // starts the run without a start pulse.
                    if ((start && ((count_q != ZERO_C) || load_xfer)) ||
                        (load_xfer && last_slot)) begin
                        state_d = ST_EXEC;
                        idx_d   = ZERO_C;
                        acc_d   = '0;
                    end
                end
            end

            ST_EXEC: begin
                if (clear) begin
                    state_d     = ST_LOAD;
                    count_d     = ZERO_C;
                    res_valid_d = 1'b0;
                end else if (out_free) begin
                    if (prog_end) begin
                        // Last result has just been accepted (or was never
                        // pending); the output register empties.
                        state_d     = ST_DONE;
                        res_valid_d = 1'b0;
                    end else begin
                        res_d       = alu_res;
                        res_neg_d   = alu_neg;
                        res_index_d = idx_q[AW-1:0];
                        res_valid_d = 1'b1;
                        idx_d       = idx_q + ONE_C;
                        if (op == OP_ACC) begin
                            acc_d = alu_res;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (clear) begin
                    state_d = ST_LOAD;
                    count_d = ZERO_C;
                end else if (start) begin
                    state_d = ST_EXEC;
                    idx_d   = ZERO_C;
                    acc_d   = '0;
                end
            end

            default: begin
                state_d     = ST_LOAD;
                count_d     = ZERO_C;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            count_q     <= ZERO_C;
            idx_q       <= ZERO_C;
            acc_q       <= '0;
            res_q       <= '0;
            res_neg_q   <= 1'b0;
            res_index_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_neg_q   <= res_neg_d;
            res_index_q <= res_index_d;
            res_valid_q <= res_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign res       = res_q;
    assign res_neg   = res_neg_q;
    assign res_index = res_index_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q == ST_EXEC);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_calculator_seq.sv
// -----------------------------------------------------------------------------
// tb_calculator_seq
//
// Directed bench for calculator_seq (DATA_W=8, DEPTH=16). Programs come from a
// table of {op, A, B, expected result, expected sign} records; multi-cycle
// corners (auto-start on full, backpressure, clear and reset mid-run) are
// hand-written sequences. Inputs change and outputs are sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_calculator_seq;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        neg;
    } vec_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [2*DATA_W+1:0] din;
    logic                din_valid;
    logic                din_ready;
    logic                start;
    logic                clear;
    logic [2*DATA_W-1:0] res;
    logic                res_neg;
    logic [AW-1:0]       res_index;
    logic                res_valid;
    logic                res_ready;
    logic                busy;
    logic                done;

    int checks = 0;
    int errors = 0;

    vec_t        tbl [9];
    logic [15:0] exp_res [DEPTH];
    logic        exp_neg [DEPTH];

    always #5 clk = ~clk;

    calculator_seq #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .start     (start),
        .clear     (clear),
        .res       (res),
        .res_neg   (res_neg),
        .res_index (res_index),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Present table entries first..first+n-1 one per cycle; records the
    // expected results for the collect step.
    task automatic load_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("din_ready_load", din_ready, 1);
            din       = {tbl[first+i].op, tbl[first+i].a, tbl[first+i].b};
            din_valid = 1'b1;
            exp_res[i] = tbl[first+i].res;
            exp_neg[i] = tbl[first+i].neg;
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_din_ready", din_ready, 1);
        check("clear_done", done, 0);
        check("clear_busy", busy, 0);
    endtask

    // Expects one result per cycle (res_ready high), then DONE.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            check($sformatf("res_valid[%0d]", i), res_valid, 1);
            check($sformatf("res[%0d]", i), res, exp_res[i]);
            check($sformatf("res_neg[%0d]", i), res_neg, exp_neg[i]);
            check($sformatf("res_index[%0d]", i), res_index, i);
        end
        @(negedge clk);
        check("end_done", done, 1);
        check("end_res_valid", res_valid, 0);
        check("end_busy", busy, 0);
    endtask

    task automatic run_and_collect(input int n);
        pulse_start();
        check("first_latency_valid", res_valid, 0);
        check("run_busy", busy, 1);
        collect(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{OP_ADD, 8'd5,   8'd3,   16'd8,     1'b0};
        tbl[1] = '{OP_SUB, 8'd3,   8'd5,   16'd2,     1'b1};
        tbl[2] = '{OP_MUL, 8'd255, 8'd255, 16'd65025, 1'b0};
        tbl[3] = '{OP_ACC, 8'd2,   8'd3,   16'd6,     1'b0};
        tbl[4] = '{OP_ACC, 8'd4,   8'd5,   16'd26,    1'b0};
        tbl[5] = '{OP_ADD, 8'd1,   8'd1,   16'd2,     1'b0};
        tbl[6] = '{OP_ACC, 8'd255, 8'd255, 16'd65051, 1'b0};
        tbl[7] = '{OP_MUL, 8'd12,  8'd10,  16'd120,   1'b0};
        tbl[8] = '{OP_SUB, 8'd0,   8'd0,   16'd0,     1'b0};

        reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        res_ready = 1'b1;

        // Reset state
        #1;
        check("rst_res", res, 0);
        check("rst_res_neg", res_neg, 0);
        check("rst_res_index", res_index, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_din_ready", din_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // ADD / SUB / MUL program
        load_words(0, 3);
        run_and_collect(3);
        pulse_clear();

        // ACC program, then rerun from DONE (acc must restart at zero)
        load_words(3, 4);
        run_and_collect(4);
        run_and_collect(4);
        pulse_clear();

        // 17 words streamed: 16 accepted, auto-start, 17th ignored
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i < 16) begin
                check("fill_din_ready", din_ready, 1);
                exp_res[i] = 16'(i + 200);
                exp_neg[i] = 1'b0;
            end else begin
                check("full_din_ready", din_ready, 0);
                check("auto_busy", busy, 1);
                check("auto_latency_valid", res_valid, 0);
            end
            din       = {OP_ADD, 8'(i), 8'd200};
            din_valid = 1'b1;
        end
        collect(16);
        pulse_clear();

        // Backpressure on the second result for 3 cycles
        load_words(0, 3);
        pulse_start();
        @(negedge clk);
        check("bp_r0", res, 8);
        check("bp_r0_index", res_index, 0);
        @(negedge clk);
        check("bp_r1", res, 2);
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_res", res, 2);
            check("bp_hold_neg", res_neg, 1);
            check("bp_hold_index", res_index, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_r2", res, 65025);
        check("bp_r2_neg", res_neg, 0);
        check("bp_r2_index", res_index, 2);
        check("bp_r2_valid", res_valid, 1);
        @(negedge clk);
        check("bp_done", done, 1);
        check("bp_end_valid", res_valid, 0);
        pulse_clear();

        // start with an empty program is ignored
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("empty_start_busy", busy, 0);
            check("empty_start_din_ready", din_ready, 1);
            check("empty_start_valid", res_valid, 0);
        end

        // clear (with start) mid-EXEC aborts; clear wins
        load_words(3, 4);
        res_ready = 1'b0;
        pulse_start();
        @(negedge clk);
        check("pre_clear_valid", res_valid, 1);
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check("abort_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_din_ready", din_ready, 1);
        res_ready = 1'b1;
        load_words(7, 1);
        run_and_collect(1);

        // Asynchronous reset between edges mid-EXEC
        pulse_clear();
        load_words(0, 3);
        res_ready = 1'b0;
        pulse_start();
        @(negedge clk);
        check("pre_reset_valid", res_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_res", res, 0);
        check("arst_res_neg", res_neg, 0);
        check("arst_res_index", res_index, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_din_ready", din_ready, 1);
        @(negedge clk);
        reset     = 1'b1;
        res_ready = 1'b1;
        load_words(8, 1);
        run_and_collect(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calculator_seq.md
Name: calculator_seq

Overview:
- Parametrised program-then-execute calculator: the host loads up to DEPTH instruction words into local instruction memory, then starts a run.
- During a run the block executes the stored program in order and streams one result per instruction over a valid/ready output.
- Adds to the previous generation:
  - generic operand width and depth
  - input and output handshakes with backpressure
  - explicit start, rerun and clear
  - an accumulate opcode.

Parameters:
DATA_W, 8, operand width; results are 2*DATA_W wide.
DEPTH, 16, instruction memory entries; must be a power of two, at least 2.
AW, $clog2(DEPTH), index width (derived, not overridden).

Ports:
clk  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset.
din  input  2*DATA_W+2  instruction word: [2W+1:2W] op, [2W-1:W] A, [W-1:0] B.
din_valid  input  1  din qualifier.
din_ready  output  1  block accepts din this cycle.
start  input  1  single-cycle run request.
clear  input  1  discard program, return to LOAD.
res  output  2*DATA_W  result magnitude.
res_neg  output  1  result sign (SUB only).
res_index  output  AW  program index of the presented result.
res_valid  output  1  result qualifier.
res_ready  input  1  consumer accepts result.
busy  output  1  high in EXEC.
done  output  1  high in DONE.

Behaviour:
Reset (reset low, asynchronous):
- state=LOAD, count=0, acc=0.
- Outputs: res=0, res_neg=0, res_index=0, res_valid=0, busy=0, done=0, din_ready=1.
- Memory contents are don't-care.
- Reset mid-run aborts the run immediately.

States:
- LOAD:
  - din_ready = (count<DEPTH).
  - A transfer is din_valid&din_ready at the edge: writes mem[count], count+1.
  - start with count>=1 goes to EXEC. start with count==0 is ignored.
  - The edge that accepts the DEPTH-th word also moves to EXEC (auto-start).
  - start and the final write in the same cycle: write is included, single transition.
- EXEC:
  - busy=1, din_ready=0.
  - Fetch pointer idx begins at 0; acc cleared on entry.
  - Output register loads mem[idx] result when (!res_valid | res_ready), then idx+1.
  - After the last (count-1) result is accepted, go to DONE with res_valid=0.
  - Throughput 1 result/cycle with res_ready held high.
  - res/res_neg/res_index are held stable while res_valid&!res_ready.
  - start ignored.
- DONE:
  - done=1, din_ready=0.
  - start reruns the same program (EXEC, idx=0, acc=0).
  - clear goes to LOAD, count=0.
- clear in EXEC:
  - Aborts: res_valid drops next edge, go to LOAD, count=0.
  - clear has priority over start.

Latency:
- start sampled at edge T; first res_valid=1 after edge T+1.

Arithmetic (operands unsigned, zero-extended to 2W):
- 00 ADD: A+B, neg=0.
- 01 SUB: A>=B gives A-B, neg=0; else B-A, neg=1.
- 10 MUL: A*B, neg=0.
- 11 ACC: acc+A*B modulo 2^(2W), neg=0; acc takes this value. acc is updated only by ACC ops.
- No overflow is possible except ACC wrap.

Test Plan:
- Load {ADD 5,3}, {SUB 3,5}, {MUL 255,255}, start, res_ready=1 -> res 8/neg0 idx0, 2/neg1 idx1, 65025/neg0 idx2 on consecutive cycles. First valid 2 edges after start. done=1 after the third accept.
- Load {ACC 2,3}, {ACC 4,5}, {ADD 1,1}, {ACC 255,255}, run -> 6, 26, 2, 65051. In DONE pulse start -> identical sequence (acc re-zeroed).
- Stream 17 words with din_valid=1 -> din_ready low after the 16th accept; 17th not written; auto-EXEC yields 16 results, idx 0..15, no wrap.
- Backpressure: res_ready=0 for 3 cycles during a run -> res/res_neg/res_index held, res_valid held high. No result skipped or duplicated on release.
- start with count=0 -> stays LOAD, busy=0. clear mid-EXEC -> res_valid=0 next cycle, LOAD, din_ready=1.
- reset low mid-EXEC (asynchronous, between edges) -> all outputs at reset values immediately. After release, a new 1-word program {SUB 0,0} gives 0/neg0.
